// File: rtl/fc_layer_scheduler.sv
// Purpose: runs a multi-layer FC network one layer at a time over the shared FC datapath.
// Latency: fc_start_o one cycle after accepted start; 2 cycles (LOAD, SWAP) per layer beyond the FC run.
// Backpressure: none; the FC controller paces each layer with fc_valid_i/fc_last_i beats.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_we_i/cfg_layer_i/...num_i layer-table write port (honoured only while idle)
//   num_layers_i, start_i         run request; layer count clamped to MAX_LAYERS
//   busy_o, done_o, err_o         run status; err_o is sticky until the next start
//   layer_idx_o                   index of the layer in flight
//   fc_start_o, fc_in/out_num_o   per-layer launch towards the FC controller
//   fc_valid_i, fc_last_i         beat / end-of-layer from the FC controller
//   wbase_o, ibuf_sel_o           weight base address and ping-pong feature buffer select
//   obuf_we_o, obuf_waddr_o       output-buffer write port
module fc_layer_scheduler #(
    parameter int MAX_LAYERS = 4,
    parameter int NODE_W     = 7,
    parameter int WADDR_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_layer_i,
    input  logic [NODE_W-1:0]  cfg_in_num_i,
    input  logic [NODE_W-1:0]  cfg_out_num_i,
    input  logic [2:0]         num_layers_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         layer_idx_o,
    output logic               fc_start_o,
    output logic [NODE_W-1:0]  fc_in_num_o,
    output logic [NODE_W-1:0]  fc_out_num_o,
    input  logic               fc_valid_i,
    input  logic               fc_last_i,
    output logic [WADDR_W-1:0] wbase_o,
    output logic               ibuf_sel_o,
    output logic               obuf_we_o,
    output logic [NODE_W-1:0]  obuf_waddr_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_SWAP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          state;
    logic [2:0]          layer_cnt;
    logic [2:0]          num_lat;
    logic [NODE_W-1:0]   beat_cnt;
    logic [WADDR_W-1:0]  wbase;
    logic                ibuf_sel;
    logic                err;

    // Layer table: plain storage, deliberately left out of reset.
    logic [NODE_W-1:0]   in_tab  [MAX_LAYERS];
    logic [NODE_W-1:0]   out_tab [MAX_LAYERS];

    logic [NODE_W-1:0]   cur_in;
    logic [NODE_W-1:0]   cur_out;
    logic [2*NODE_W-1:0] layer_prod;
    logic                layer_act;
    logic [2:0]          num_clamped;

    assign cur_in      = in_tab[layer_cnt[1:0]];
    assign cur_out     = out_tab[layer_cnt[1:0]];
    // Full-width product so large layers are not truncated before the add.
    assign layer_prod  = cur_in * cur_out;
    assign layer_act   = (state == S_LOAD) || (state == S_RUN) || (state == S_SWAP);
    assign num_clamped = (num_layers_i > 3'(MAX_LAYERS)) ? 3'(MAX_LAYERS) : num_layers_i;

    always_ff @(posedge clk) begin
        if (cfg_we_i && (state == S_IDLE)) begin
            in_tab[cfg_layer_i]  <= cfg_in_num_i;
            out_tab[cfg_layer_i] <= cfg_out_num_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            layer_cnt <= '0;
            num_lat   <= '0;
            beat_cnt  <= '0;
            wbase     <= '0;
            ibuf_sel  <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        err       <= 1'b0;
                        layer_cnt <= '0;
                        wbase     <= '0;
                        ibuf_sel  <= 1'b0;
                        num_lat   <= num_clamped;
                        state     <= (num_layers_i == 3'd0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    beat_cnt <= '0;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    if (fc_valid_i) begin
                        beat_cnt <= beat_cnt + NODE_W'(1);
                    end
                    if (fc_last_i) begin
                        if ((beat_cnt + NODE_W'(1)) != cur_out) begin
                            err <= 1'b1;
                        end
                        state <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    wbase     <= wbase + WADDR_W'(layer_prod);
                    ibuf_sel  <= ~ibuf_sel;
                    layer_cnt <= layer_cnt + 3'd1;
                    state     <= ((layer_cnt + 3'd1) < num_lat) ? S_LOAD : S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = (state != S_IDLE);
    assign done_o       = (state == S_DONE);
    assign err_o        = err;
    assign layer_idx_o  = layer_cnt[1:0];
    assign fc_start_o   = (state == S_LOAD);
    // Node counts are only meaningful while a layer is in flight; zero otherwise.
    assign fc_in_num_o  = layer_act ? cur_in  : '0;
    assign fc_out_num_o = layer_act ? cur_out : '0;
    assign wbase_o      = wbase;
    assign ibuf_sel_o   = ibuf_sel;
    assign obuf_we_o    = (state == S_RUN) && fc_valid_i;
    assign obuf_waddr_o = beat_cnt;

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Purpose: directed self-checking bench for fc_layer_scheduler.
// Latency: inputs driven 1ns after the rising edge, outputs sampled before the next edge.
// Backpressure: bench plays the FC controller, issuing beats back to back.
module tb_fc_layer_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we_i;
    logic [1:0]  cfg_layer_i;
    logic [6:0]  cfg_in_num_i;
    logic [6:0]  cfg_out_num_i;
    logic [2:0]  num_layers_i;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  layer_idx_o;
    logic        fc_start_o;
    logic [6:0]  fc_in_num_o;
    logic [6:0]  fc_out_num_o;
    logic        fc_valid_i;
    logic        fc_last_i;
    logic [15:0] wbase_o;
    logic        ibuf_sel_o;
    logic        obuf_we_o;
    logic [6:0]  obuf_waddr_o;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int snap;

    always #5 clk = ~clk;

    fc_layer_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we_i     (cfg_we_i),
        .cfg_layer_i  (cfg_layer_i),
        .cfg_in_num_i (cfg_in_num_i),
        .cfg_out_num_i(cfg_out_num_i),
        .num_layers_i (num_layers_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .layer_idx_o  (layer_idx_o),
        .fc_start_o   (fc_start_o),
        .fc_in_num_o  (fc_in_num_o),
        .fc_out_num_o (fc_out_num_o),
        .fc_valid_i   (fc_valid_i),
        .fc_last_i    (fc_last_i),
        .wbase_o      (wbase_o),
        .ibuf_sel_o   (ibuf_sel_o),
        .obuf_we_o    (obuf_we_o),
        .obuf_waddr_o (obuf_waddr_o)
    );

    always @(posedge clk) begin
        if (fc_start_o === 1'b1) start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_busy"},  32'(busy_o), 0);
        check({tag, "_done"},  32'(done_o), 0);
        check({tag, "_err"},   32'(err_o), 0);
        check({tag, "_fcst"},  32'(fc_start_o), 0);
        check({tag, "_we"},    32'(obuf_we_o), 0);
        check({tag, "_idx"},   32'(layer_idx_o), 0);
        check({tag, "_wbase"}, 32'(wbase_o), 0);
        check({tag, "_ibuf"},  32'(ibuf_sel_o), 0);
        check({tag, "_waddr"}, 32'(obuf_waddr_o), 0);
        check({tag, "_in"},    32'(fc_in_num_o), 0);
        check({tag, "_out"},   32'(fc_out_num_o), 0);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [6:0] nin, input logic [6:0] nout);
        cfg_we_i = 1'b1; cfg_layer_i = idx; cfg_in_num_i = nin; cfg_out_num_i = nout;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic go(input logic [2:0] n);
        start_i = 1'b1; num_layers_i = n;
        tick();
        start_i = 1'b0;
    endtask

    // Entered just after the edge into LOAD; returns just after the edge leaving SWAP.
    task automatic run_layer(input int ein, input int eout, input int ewb, input int eibuf,
                             input int eidx, input int beats, input bit poke);
        check("load_fcst",  32'(fc_start_o), 1);
        check("load_busy",  32'(busy_o), 1);
        check("load_in",    32'(fc_in_num_o), ein);
        check("load_out",   32'(fc_out_num_o), eout);
        check("load_wbase", 32'(wbase_o), ewb);
        check("load_ibuf",  32'(ibuf_sel_o), eibuf);
        check("load_idx",   32'(layer_idx_o), eidx);
        fc_valid_i = 1'b1;
        #1;
        check("load_no_we", 32'(obuf_we_o), 0);
        fc_valid_i = 1'b0;
        tick();
        check("run_fcst", 32'(fc_start_o), 0);
        if (poke) begin
            start_i = 1'b1; num_layers_i = 3'd1;
            cfg_we_i = 1'b1; cfg_layer_i = 2'd0; cfg_in_num_i = 7'd9; cfg_out_num_i = 7'd9;
            tick();
            start_i = 1'b0; cfg_we_i = 1'b0;
            check("poke_fcst", 32'(fc_start_o), 0);
            check("poke_busy", 32'(busy_o), 1);
            check("poke_in",   32'(fc_in_num_o), ein);
            check("poke_out",  32'(fc_out_num_o), eout);
        end
        for (int b = 0; b < beats; b++) begin
            fc_valid_i = 1'b1;
            fc_last_i  = (b == beats - 1);
            #1;
            check("beat_we",    32'(obuf_we_o), 1);
            check("beat_waddr", 32'(obuf_waddr_o), b);
            tick();
        end
        fc_valid_i = 1'b0; fc_last_i = 1'b0;
        check("swap_done", 32'(done_o), 0);
        check("swap_busy", 32'(busy_o), 1);
        tick();
    endtask

    initial begin
        rst = 1'b1; cfg_we_i = 1'b0; cfg_layer_i = '0; cfg_in_num_i = '0; cfg_out_num_i = '0;
        num_layers_i = '0; start_i = 1'b0; fc_valid_i = 1'b0; fc_last_i = 1'b0;
        tick(); tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        tick();

        // Single layer 5 -> 3.
        wr(2'd0, 7'd5, 7'd3);
        snap = start_cnt;
        go(3'd1);
        run_layer(5, 3, 0, 0, 0, 3, 1'b0);
        check("t1_done",  32'(done_o), 1);
        check("t1_busy",  32'(busy_o), 1);
        check("t1_err",   32'(err_o), 0);
        check("t1_wbase", 32'(wbase_o), 15);
        tick();
        check("t1_done_fall", 32'(done_o), 0);
        check("t1_busy_fall", 32'(busy_o), 0);
        check("t1_starts", 32'(start_cnt - snap), 1);

        // Three layers 120->84, 84->10, 10->10.
        wr(2'd0, 7'd120, 7'd84);
        wr(2'd1, 7'd84, 7'd10);
        wr(2'd2, 7'd10, 7'd10);
        snap = start_cnt;
        go(3'd3);
        run_layer(120, 84, 0, 0, 0, 84, 1'b0);
        run_layer(84, 10, 10080, 1, 1, 10, 1'b0);
        run_layer(10, 10, 10920, 0, 2, 10, 1'b0);
        check("t2_done",  32'(done_o), 1);
        check("t2_wbase", 32'(wbase_o), 11020);
        check("t2_ibuf",  32'(ibuf_sel_o), 1);
        tick();
        check("t2_starts", 32'(start_cnt - snap), 3);

        // Zero layers: straight to DONE.
        snap = start_cnt;
        go(3'd0);
        check("t3_done", 32'(done_o), 1);
        check("t3_busy", 32'(busy_o), 1);
        check("t3_fcst", 32'(fc_start_o), 0);
        tick();
        check("t3_done_fall", 32'(done_o), 0);
        check("t3_starts", 32'(start_cnt - snap), 0);

        // Seven requested, clamped to four.
        wr(2'd0, 7'd2, 7'd3);
        wr(2'd1, 7'd3, 7'd2);
        wr(2'd2, 7'd4, 7'd1);
        wr(2'd3, 7'd1, 7'd4);
        snap = start_cnt;
        go(3'd7);
        run_layer(2, 3, 0, 0, 0, 3, 1'b0);
        run_layer(3, 2, 6, 1, 1, 2, 1'b0);
        run_layer(4, 1, 12, 0, 2, 1, 1'b0);
        run_layer(1, 4, 16, 1, 3, 4, 1'b0);
        check("t4_done",  32'(done_o), 1);
        check("t4_wbase", 32'(wbase_o), 20);
        check("t4_ibuf",  32'(ibuf_sel_o), 0);
        tick();
        check("t4_starts", 32'(start_cnt - snap), 4);

        // Early last beat: err set and held, cleared by next start.
        go(3'd1);
        run_layer(2, 3, 0, 0, 0, 2, 1'b0);
        check("t5_done", 32'(done_o), 1);
        check("t5_err",  32'(err_o), 1);
        tick();
        check("t5_err_hold", 32'(err_o), 1);
        go(3'd1);
        check("t5_err_clr", 32'(err_o), 0);
        run_layer(2, 3, 0, 0, 0, 3, 1'b0);
        check("t5_err_ok", 32'(err_o), 0);
        tick();

        // start/cfg pulsed during RUN are ignored.
        snap = start_cnt;
        go(3'd1);
        run_layer(2, 3, 0, 0, 0, 3, 1'b1);
        check("t6_done", 32'(done_o), 1);
        tick();
        check("t6_starts", 32'(start_cnt - snap), 1);
        go(3'd1);
        run_layer(2, 3, 0, 0, 0, 3, 1'b0);
        tick();

        // Reset mid-RUN of layer 1, then a fresh run from layer 0.
        go(3'd2);
        run_layer(2, 3, 0, 0, 0, 3, 1'b0);
        check("t7_l1_fcst",  32'(fc_start_o), 1);
        check("t7_l1_wbase", 32'(wbase_o), 6);
        check("t7_l1_idx",   32'(layer_idx_o), 1);
        tick();
        fc_valid_i = 1'b1;
        tick();
        fc_valid_i = 1'b0;
        check("t7_mid_waddr", 32'(obuf_waddr_o), 1);
        rst = 1'b1;
        tick();
        chk_reset_vals("t7");
        rst = 1'b0;
        tick();
        go(3'd1);
        run_layer(2, 3, 0, 0, 0, 3, 1'b0);
        check("t7_done", 32'(done_o), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_layer_scheduler.md
# fc_layer_scheduler

Sequences a multi-layer fully-connected network over the single shared FC datapath. It holds a small layer table of input and output node counts. On start it launches one FC layer at a time, issuing a start pulse with node counts to the FC controller and waiting for its last beat. Between layers it advances the weight-buffer base address and swaps the ping-pong feature buffers, so each layer's outputs become the next layer's inputs.

## Interface
- MAX_LAYERS, 4: layer table depth.
- NODE_W, 7: node-count and buffer-address width.
- WADDR_W, 16: weight base-address width.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we_i  in  1  layer-table write strobe.
- cfg_layer_i  in  2  table entry index.
- cfg_in_num_i  in  NODE_W  input node count for the entry.
- cfg_out_num_i  in  NODE_W  output node count for the entry.
- num_layers_i  in  3  number of layers to run; sampled at accepted start.
- start_i  in  1  run request.
- busy_o  out  1  high from accepted start until done_o.
- done_o  out  1  one-cycle pulse at end of run.
- err_o  out  1  sticky beat-count mismatch flag; cleared at accepted start.
- layer_idx_o  out  2  current layer index.
- fc_start_o  out  1  one-cycle start pulse to the FC controller.
- fc_in_num_o / fc_out_num_o  out  NODE_W  node counts of the current layer.
- fc_valid_i  in  1  one output node complete (from the FC controller).
- fc_last_i  in  1  final output node of the layer; coincides with the last fc_valid_i.
- wbase_o  out  WADDR_W  weight-buffer base address of the current layer.
- ibuf_sel_o  out  1  ping-pong buffer read as ifmap; outputs go to !ibuf_sel_o.
- obuf_we_o  out  1  output-buffer write enable.
- obuf_waddr_o  out  NODE_W  output-buffer write address.

## Operation
- Layer table:
  - Written when cfg_we_i=1 and state is IDLE; writes while busy are ignored.
  - Entries are not cleared by rst and contain unknown values until written.
- FSM states:
  - IDLE: start_i=1 -> if num_layers_i=0 go to DONE, else LOAD. The start is accepted, err_o is cleared, layer_idx=0, wbase=0, ibuf_sel=0, and the layer count is latched as min(num_layers_i, MAX_LAYERS).
  - LOAD: fc_start_o=1; beat counter cleared; -> RUN.
  - RUN: each fc_valid_i gives obuf_we_o=1 (combinational, same cycle) with obuf_waddr_o=beat count, then the count is incremented. On fc_last_i: if count+1 != fc_out_num_o, set err_o; -> SWAP.
  - SWAP: wbase += in_num*out_num (modulo 2^WADDR_W, product computed at full 2*NODE_W width); ibuf_sel toggles; layer_idx++. -> LOAD if more layers remain, else DONE.
  - DONE: done_o=1; -> IDLE.
- Ignored inputs:
  - start_i in any state other than IDLE.
  - fc_valid_i / fc_last_i outside RUN (obuf_we_o stays 0).
- fc_in_num_o / fc_out_num_o are driven from the table entry at layer_idx, stable from LOAD through RUN.

## Timing
- Reset values: busy_o=0, done_o=0, err_o=0, fc_start_o=0, obuf_we_o=0, layer_idx_o=0, wbase_o=0, ibuf_sel_o=0, obuf_waddr_o=0, fc_in_num_o/fc_out_num_o=0. The state is IDLE.
- Start latency: start_i sampled at edge N -> fc_start_o and busy_o high during cycle N+1.
- Per-layer overhead: 2 cycles (LOAD, SWAP) beyond the FC controller run time.
- Output timing relative to the fc_last_i edge:
  - done_o rises 2 cycles after fc_last_i of the final layer (SWAP, then DONE).
  - busy_o falls in the same cycle done_o falls.
- rst asserted in any state: all outputs return to reset values at the next edge, and any in-flight layer is abandoned.
- fc_valid_i and fc_last_i in the same cycle: the beat is written, then the layer ends.

## Test plan
- Single layer, in=5, out=3: fc_start_o pulses once with 5/3. Three fc_valid_i beats give obuf_waddr_o 0, 1, 2. done_o is seen 2 cycles after fc_last_i, and err_o=0.
- Three layers 120->84, 84->10, 10->10: wbase_o reads 0, 10080, 10920 across the layers. ibuf_sel_o reads 0, 1, 0, and exactly three fc_start_o pulses are seen.
- num_layers_i=0: done_o in cycle N+1, no fc_start_o; num_layers_i=7 runs 4 layers.
- Layer out=3 but fc_last_i arrives on the 2nd beat: err_o=1 and held after done_o; next start clears it.
- start_i and cfg_we_i pulsed during RUN: no restart, and the table is unchanged on the next run.
- rst asserted mid-RUN of layer 1: next cycle all outputs are at reset values. A fresh start runs from layer 0 with wbase_o=0.
